// File: rtl/state_trace.sv
// Records every change of an upstream 2-bit state code into a small FIFO.
// Each entry holds {from, to, hold}. Also counts st3->st0 loops and flags dropped entries.
module state_trace #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [1:0]                state,
  input  logic                      clr,
  output logic [4+HOLD_W-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic [7:0]                loops,
  output logic                      ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 4 + HOLD_W;
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

  logic [1:0]        prev_reg;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next, count_after_pop;
  logic [EW-1:0]     out_data_reg, out_data_next;
  logic              out_valid_reg, out_valid_next;
  logic [7:0]        loops_reg, loops_next;
  logic              ovf_reg, ovf_next;

  logic          trans, pop, full, push, drop;
  logic [EW-1:0] entry;

  always_comb begin
    trans = (state != prev_reg);
    pop   = out_valid_reg && out_ready;
    full  = (count_reg == CW'(DEPTH));
    // A full FIFO can still take a push when the head leaves on the same edge.
    push  = trans && (!full || pop);
    drop  = trans && full && !pop;
    entry = {prev_reg, state, hold_reg};

    hold_next = hold_reg;
    if (trans)
      hold_next = HOLD_W'(1);
    else if (hold_reg != HOLD_MAX)
      hold_next = hold_reg + HOLD_W'(1);

    rd_ptr_next     = rd_ptr_reg + PW'(pop);
    wr_ptr_next     = wr_ptr_reg + PW'(push);
    count_after_pop = count_reg - CW'(pop);
    count_next      = count_after_pop + CW'(push);

    // Output register tracks the head after this edge; a push into an
    // otherwise empty FIFO bypasses the memory.
    out_data_next = out_data_reg;
    if (count_after_pop != '0)
      out_data_next = mem[rd_ptr_next];
    else if (push)
      out_data_next = entry;
    out_valid_next = (count_next != '0);

    loops_next = loops_reg;
    ovf_next   = ovf_reg | drop;
    if (trans && prev_reg == 2'b11 && state == 2'b00 && loops_reg != 8'hFF)
      loops_next = loops_reg + 8'd1;
    if (clr) begin
      loops_next = '0;
      ovf_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!res && push)
      mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      prev_reg      <= 2'b00;
      hold_reg      <= HOLD_W'(1);
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      loops_reg     <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      prev_reg      <= state;
      hold_reg      <= hold_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      loops_reg     <= loops_next;
      ovf_reg       <= ovf_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign count     = count_reg;
  assign loops     = loops_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_state_trace.sv
// Directed bench for state_trace with DEPTH=4, HOLD_W=4.
module tb_state_trace;

  logic       clk = 1'b0;
  logic       res, clr, out_ready;
  logic [1:0] state;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] count;
  logic [7:0] loops;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  logic [7:0] got [16];
  int got_n;

  state_trace #(.DEPTH(4), .HOLD_W(4)) dut (
    .clk(clk), .res(res), .state(state), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .loops(loops), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1; clr = 1'b0; out_ready = 1'b0; state = 2'b00;
    step();
    res = 1'b0;
  endtask

  // Pops until empty, collecting the head seen before each pop.
  task automatic drain();
    int budget = 0;
    out_ready = 1'b1;
    got_n = 0;
    while (out_valid && budget < 16) begin
      got[got_n] = out_data;
      $display("pop entry=%h count=%0d", out_data, count);
      got_n++;
      budget++;
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1; clr = 1'b0; out_ready = 1'b0; state = 2'b10;
    step();
    res = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++; if (loops !== 8'd0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_loops_ovf got=%0d/%b exp=0/0", loops, ovf); end
  endtask

  task automatic test_first_entry();
    do_reset();
    state = 2'b00;
    repeat (3) step();
    total++; if (out_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL first_no_trans got valid=%b count=%0d exp 0/0", out_valid, count); end
    state = 2'b01;
    step();
    $display("push 00->01 valid=%b data=%h count=%0d", out_valid, out_data, count);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'h14) begin bad++; $display("FAIL first_data got=%h exp=14", out_data); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", count); end
  endtask

  task automatic test_drain_loops();
    logic [1:0] seq [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [7:0] exp [4] = '{8'h12, 8'h61, 8'hB1, 8'hC1};
    do_reset();
    state = 2'b00;
    step();
    out_ready = 1'b1;
    got_n = 0;
    for (int i = 0; i < 8; i++) begin
      state = seq[i];
      step();
      if (out_valid && got_n < 16) begin
        got[got_n] = out_data;
        $display("pop entry=%h count=%0d", out_data, count);
        got_n++;
      end
    end
    out_ready = 1'b0;
    total++; if (got_n !== 4) begin bad++; $display("FAIL drain_n got=%0d exp=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL drain_entry%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    total++; if (loops !== 8'd1) begin bad++; $display("FAIL drain_loops got=%0d exp=1", loops); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] exp [4] = '{8'h12, 8'h61, 8'hB1, 8'hC1};
    do_reset();
    state = 2'b00;
    step();
    for (int i = 0; i < 5; i++) begin
      state = seq[i];
      step();
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    drain();
    total++; if (got_n !== 4) begin bad++; $display("FAIL ovf_drain_n got=%0d exp=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL ovf_entry%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
  endtask

  task automatic test_full_pushpop();
    logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp [4] = '{8'h61, 8'hB1, 8'hC1, 8'h11};
    do_reset();
    state = 2'b00;
    step();
    for (int i = 0; i < 4; i++) begin
      state = seq[i];
      step();
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
    out_ready = 1'b1;
    state = 2'b01;
    step();
    $display("push+pop on full count=%0d head=%h ovf=%b", count, out_data, ovf);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL pp_count got=%0d exp=4", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%b exp=0", ovf); end
    total++; if (out_data !== 8'h61) begin bad++; $display("FAIL pp_head got=%h exp=61", out_data); end
    drain();
    total++; if (got_n !== 4) begin bad++; $display("FAIL pp_drain_n got=%0d exp=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL pp_entry%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_hold_sat();
    do_reset();
    state = 2'b00;
    step();
    state = 2'b10;
    repeat (20) step();
    state = 2'b11;
    step();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL sat_count got=%0d exp=2", count); end
    drain();
    total++; if (got_n !== 2) begin bad++; $display("FAIL sat_n got=%0d exp=2", got_n); end
    total++; if (got[0] !== 8'h22) begin bad++; $display("FAIL sat_entry0 got=%h exp=22", got[0]); end
    total++; if (got[1] !== 8'hBF) begin bad++; $display("FAIL sat_entry1 got=%h exp=BF", got[1]); end
  endtask

  task automatic test_reset_mid_clr();
    logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    state = 2'b00;
    step();
    for (int i = 0; i < 3; i++) begin
      state = seq[i];
      step();
    end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    res = 1'b1; clr = 1'b1; state = 2'b00;
    step();
    res = 1'b0; clr = 1'b0;
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset got count=%0d valid=%b exp 0/0", count, out_valid); end
    total++; if (loops !== 8'd0) begin bad++; $display("FAIL mid_loops got=%0d exp=0", loops); end

    step();
    for (int i = 0; i < 4; i++) begin
      state = seq[i];
      step();
    end
    total++; if (loops !== 8'd1) begin bad++; $display("FAIL clr_pre_loops got=%0d exp=1", loops); end
    for (int i = 0; i < 3; i++) begin
      state = seq[i];
      step();
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL clr_pre_ovf got=%b exp=1", ovf); end
    state = 2'b00; clr = 1'b1;
    step();
    clr = 1'b0;
    $display("clr with 11->00 loops=%0d ovf=%b count=%0d", loops, ovf, count);
    total++; if (loops !== 8'd0) begin bad++; $display("FAIL clr_loops got=%0d exp=0", loops); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b exp=0", ovf); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL clr_count got=%0d exp=4", count); end
  endtask

  initial begin
    res = 1'b1; clr = 1'b0; out_ready = 1'b0; state = 2'b00;
    test_reset();
    test_first_entry();
    test_drain_loops();
    test_overflow();
    test_full_pushpop();
    test_hold_sat();
    test_reset_mid_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/state_trace.md
STATE_TRACE -- requirements
Module: state_trace

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of trace FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter HOLD_W, default 4, meaning the width of the saturating hold counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port res, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port state, input, 2 bits: the state code from the upstream FSM (00 st0, 01 st1, 10 st2, 11 st3), sampled every clk edge.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of loops and ovf.
REQ-007 SHALL have port out_data, output, 4+HOLD_W bits: the FIFO head as {from[1:0], to[1:0], hold[HOLD_W-1:0]}.
REQ-008 SHALL have port out_valid, output, 1 bit: high when the FIFO is non-empty.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-010 SHALL have port count, output, clog2(DEPTH)+1 bits: the current FIFO occupancy.
REQ-011 SHALL have port loops, output, 8 bits: completed st3->st0 transitions, saturating.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, set when a transition entry is dropped.

Function
REQ-013 SHALL hold register prev (2 bits), which takes the value of state on every edge not in reset.
REQ-014 SHALL hold register hold (HOLD_W bits), counting consecutive samples equal to prev; on state==prev, hold becomes min(hold+1, 2^HOLD_W-1).
REQ-015 SHALL define a transition as state!=prev at an edge; on that edge, entry {prev, state, hold} is pushed and hold is set to 1.
REQ-016 SHALL pop the head on an edge with out_valid && out_ready; out_data then shows the next entry in the following cycle.
REQ-017 SHALL register out_data and out_valid; an entry pushed into an empty FIFO at edge N is visible with out_valid=1 in the cycle after edge N (latency 1).
REQ-018 SHALL accept a push when full if a pop occurs on the same edge; count is unchanged.
REQ-019 SHALL drop a push when full with no pop, leaving FIFO contents and count unchanged and setting ovf=1.
REQ-020 SHALL leave count unchanged on a pop when empty; out_data holds its last value with out_valid=0.
REQ-021 SHALL apply a simultaneous push and pop on a non-empty, non-full FIFO: count is unchanged and order is preserved.
REQ-022 SHALL increment loops on a transition with prev==11 and state==00, saturating at 255.
REQ-023 SHALL, when clr=1, clear loops and ovf to 0 on that edge; clr has priority over a same-edge increment or overflow set.
REQ-024 SHALL NOT let clr affect the FIFO, prev or hold.
REQ-025 SHALL use wrap-around read and write pointers modulo DEPTH.

Reset
REQ-026 SHALL, when res=1 at an edge, set prev=00, hold=1, count=0, out_valid=0, out_data=0, loops=0 and ovf=0; the state input is ignored on that edge.
REQ-027 SHALL discard all queued entries when reset is asserted mid-operation, with no pop handshake; res has priority over clr, push and pop.
REQ-028 SHALL detect no transition on the first edge after reset release if state==00, and hold then becomes 2.

Verification
REQ-029 SHALL be verified with: reset, then state 00 x3 edges, then 01 -> one entry {00,01,hold=4}, out_valid=1 one cycle later, count=1.
REQ-030 SHALL be verified with: the sequence 00->01->10->11->00 with out_ready=1 -> four entries drained in order and loops=1.
REQ-031 SHALL be verified with: out_ready=0 and 5 transitions -> count=4, ovf=1, and the 5th entry absent after draining.
REQ-032 SHALL be verified with: full FIFO, a transition on the same edge as a pop -> count stays 4 and ovf stays 0.
REQ-033 SHALL be verified with: state held at 10 for 20 edges, then 11 -> entry hold=15 (saturated).
REQ-034 SHALL be verified with: res=1 while count=3, plus clr asserted on the same edge as an 11->00 transition -> after reset count=0, out_valid=0; separately, clr yields loops=0.
